// File: rtl/bypassed_register_file_if.sv
// Operand/writeback/issue bus of the bypassed register file.
// All flat buses carry port 0 in the least-significant slice.
interface bypassed_register_file_if #(
    parameter int SIZE           = 32,
    parameter int REGISTER_COUNT = 32,
    parameter int READ_COUNT     = 2,
    parameter int WRITE_COUNT    = 2,
    parameter int RESERVE_COUNT  = 2
);
    localparam int INDEX_SIZE = $clog2(REGISTER_COUNT);

    // No valid/ready: every strobe is a single-cycle command sampled at the
    // rising edge, and reads are combinational with no back-pressure.
    logic [READ_COUNT*INDEX_SIZE-1:0]    read_index_flat;
    logic [READ_COUNT*SIZE-1:0]          read_data_flat;
    logic [READ_COUNT-1:0]               read_pending_flat;
    logic [WRITE_COUNT-1:0]              write_enable_flat;
    logic [WRITE_COUNT*INDEX_SIZE-1:0]   write_index_flat;
    logic [WRITE_COUNT*SIZE-1:0]         write_data_flat;
    logic [RESERVE_COUNT-1:0]            reserve_enable_flat;
    logic [RESERVE_COUNT*INDEX_SIZE-1:0] reserve_index_flat;

    modport master (
        output read_index_flat,
        output write_enable_flat,
        output write_index_flat,
        output write_data_flat,
        output reserve_enable_flat,
        output reserve_index_flat,
        input  read_data_flat,
        input  read_pending_flat
    );

    modport slave (
        input  read_index_flat,
        input  write_enable_flat,
        input  write_index_flat,
        input  write_data_flat,
        input  reserve_enable_flat,
        input  reserve_index_flat,
        output read_data_flat,
        output read_pending_flat
    );
endinterface

// File: rtl/bypassed_register_file.sv
// Multi-ported register file with write-to-read bypass, highest-port-wins
// writes and a per-register pending bit set by issue and cleared by writeback.
module bypassed_register_file #(
    parameter int SIZE           = 32,
    parameter int REGISTER_COUNT = 32,
    parameter int READ_COUNT     = 2,
    parameter int WRITE_COUNT    = 2,
    parameter int RESERVE_COUNT  = 2,
    parameter bit BYPASS         = 1'b1,
    parameter bit ZERO_REGISTER  = 1'b1
) (
    input logic                     clock,
    input logic                     reset,
    bypassed_register_file_if.slave rf
);
    localparam int INDEX_SIZE = $clog2(REGISTER_COUNT);

    logic [INDEX_SIZE-1:0]    read_index    [READ_COUNT];
    logic [INDEX_SIZE-1:0]    write_index   [WRITE_COUNT];
    logic [SIZE-1:0]          write_data    [WRITE_COUNT];
    logic [INDEX_SIZE-1:0]    reserve_index [RESERVE_COUNT];
    logic [READ_COUNT-1:0]    read_valid;
    logic [WRITE_COUNT-1:0]   write_valid;
    logic [RESERVE_COUNT-1:0] reserve_valid;

    logic [SIZE-1:0]           data_q [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] pending_q;

    logic [REGISTER_COUNT-1:0] write_hit;
    logic [REGISTER_COUNT-1:0] reserve_hit;
    logic [SIZE-1:0]           write_value  [REGISTER_COUNT];
    logic [READ_COUNT-1:0]     bypass_hit;
    logic [SIZE-1:0]           bypass_value [READ_COUNT];

    // An index addresses real storage only if it is in range and is not the hardwired zero.
    function automatic logic index_usable(input logic [INDEX_SIZE-1:0] idx);
        if (32'(idx) >= 32'(REGISTER_COUNT)) return 1'b0;
        if (ZERO_REGISTER && (idx == '0)) return 1'b0;
        return 1'b1;
    endfunction

    always_comb begin
        for (int p = 0; p < READ_COUNT; p++) begin
            read_index[p] = rf.read_index_flat[p*INDEX_SIZE +: INDEX_SIZE];
            read_valid[p] = index_usable(read_index[p]);
        end
    end

    always_comb begin
        for (int w = 0; w < WRITE_COUNT; w++) begin
            write_index[w] = rf.write_index_flat[w*INDEX_SIZE +: INDEX_SIZE];
            write_data[w]  = rf.write_data_flat[w*SIZE +: SIZE];
            write_valid[w] = rf.write_enable_flat[w] && index_usable(write_index[w]);
        end
    end

    always_comb begin
        for (int s = 0; s < RESERVE_COUNT; s++) begin
            reserve_index[s] = rf.reserve_index_flat[s*INDEX_SIZE +: INDEX_SIZE];
            reserve_valid[s] = rf.reserve_enable_flat[s] && index_usable(reserve_index[s]);
        end
    end

    // Ports are scanned in ascending order so the highest-numbered match overrides.
    always_comb begin
        write_hit   = '0;
        reserve_hit = '0;
        for (int r = 0; r < REGISTER_COUNT; r++) begin
            write_value[r] = '0;
            for (int w = 0; w < WRITE_COUNT; w++) begin
                if (write_valid[w] && (write_index[w] == INDEX_SIZE'(r))) begin
                    write_hit[r]   = 1'b1;
                    write_value[r] = write_data[w];
                end
            end
            for (int s = 0; s < RESERVE_COUNT; s++) begin
                if (reserve_valid[s] && (reserve_index[s] == INDEX_SIZE'(r))) begin
                    reserve_hit[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bypass_hit = '0;
        for (int p = 0; p < READ_COUNT; p++) begin
            bypass_value[p] = '0;
            for (int w = 0; w < WRITE_COUNT; w++) begin
                if (write_valid[w] && (write_index[w] == read_index[p])) begin
                    bypass_hit[p]   = 1'b1;
                    bypass_value[p] = write_data[w];
                end
            end
        end
    end

    // A reserve in the same cycle as a write means a newer producer was issued,
    // so the set takes priority over the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                data_q[r] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                if (write_hit[r]) begin
                    data_q[r] <= write_value[r];
                end
                if (reserve_hit[r]) begin
                    pending_q[r] <= 1'b1;
                end else if (write_hit[r]) begin
                    pending_q[r] <= 1'b0;
                end
            end
        end
    end

    // Reset gates the outputs directly so forwarded write data cannot leak during reset.
    always_comb begin
        rf.read_data_flat    = '0;
        rf.read_pending_flat = '0;
        for (int p = 0; p < READ_COUNT; p++) begin
            if (reset && read_valid[p]) begin
                if (BYPASS && bypass_hit[p]) begin
                    rf.read_data_flat[p*SIZE +: SIZE] = bypass_value[p];
                end else begin
                    rf.read_data_flat[p*SIZE +: SIZE] = data_q[read_index[p]];
                    rf.read_pending_flat[p]           = pending_q[read_index[p]];
                end
            end
        end
    end
endmodule
